// File: rtl/clb_pkg.sv
// Shared definitions for the CLB switch box: select codes, side order, index helpers.
package clb_pkg;

  // 2-bit mux select codes; SEL_OFF drives the routed output to 0.
  localparam logic [1:0] SEL_0   = 2'd0;
  localparam logic [1:0] SEL_1   = 2'd1;
  localparam logic [1:0] SEL_2   = 2'd2;
  localparam logic [1:0] SEL_OFF = 2'd3;

  // Side order used for config fields and packed side vectors.
  localparam int unsigned SIDE_N    = 0;
  localparam int unsigned SIDE_E    = 1;
  localparam int unsigned SIDE_S    = 2;
  localparam int unsigned SIDE_W    = 3;
  localparam int unsigned NUM_SIDES = 4;

  // Source side for output side `side` under select `code` (clockwise from the next side).
  function automatic int unsigned src_side(input int unsigned side, input int unsigned code);
    return (side + 1 + code) % NUM_SIDES;
  endfunction

  // Pin index of routed double track `trk` on `side`. E and S carry routed doubles in the
  // upper half so the fixed pass-through wires own the remaining half on every side.
  function automatic int unsigned dbl_pos(input int unsigned side, input int unsigned trk,
                                          input int unsigned half);
    return (side == SIDE_E || side == SIDE_S) ? half + trk : trk;
  endfunction

endpackage

// File: rtl/clb_sb_mux4.sv
// Three-input routing mux with an off code.
// Ports: d0..d2 data inputs, sel 2-bit select, y_c combinational output (0 for SEL_OFF).
module clb_sb_mux4
  import clb_pkg::*;
(
  input  logic       d0,
  input  logic       d1,
  input  logic       d2,
  input  logic [1:0] sel,
  output logic       y_c
);

  always_comb begin
    y_c = 1'b0;
    case (sel)
      SEL_0:   y_c = d0;
      SEL_1:   y_c = d1;
      SEL_2:   y_c = d2;
      default: y_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/clb_switch_box_sr.sv
// CLB switch box with a serially loaded, double-buffered configuration.
// Ports: clk/rst (async active-high); cfg_en/cfg_in shift the shadow chain, cfg_out is its
// tail; cfg_commit loads shadow into active when cfg_full, else pulses cfg_err.
// <side>_single_in/out (WS) and <side>_double_in/out (WD) are the routing tracks.
module clb_switch_box_sr
  import clb_pkg::*;
#(
  parameter int unsigned WS      = 8,
  parameter int unsigned WD      = 4,
  parameter int unsigned REG_OUT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_en,
  input  logic          cfg_in,
  output logic          cfg_out,
  input  logic          cfg_commit,
  output logic          cfg_full,
  output logic          cfg_err,
  input  logic [WS-1:0] north_single_in,
  input  logic [WS-1:0] east_single_in,
  input  logic [WS-1:0] south_single_in,
  input  logic [WS-1:0] west_single_in,
  output logic [WS-1:0] north_single_out,
  output logic [WS-1:0] east_single_out,
  output logic [WS-1:0] south_single_out,
  output logic [WS-1:0] west_single_out,
  input  logic [WD-1:0] north_double_in,
  input  logic [WD-1:0] east_double_in,
  input  logic [WD-1:0] south_double_in,
  input  logic [WD-1:0] west_double_in,
  output logic [WD-1:0] north_double_out,
  output logic [WD-1:0] east_double_out,
  output logic [WD-1:0] south_double_out,
  output logic [WD-1:0] west_double_out
);

  localparam int unsigned CW   = 8 * WS + 4 * WD;
  localparam int unsigned HD   = WD / 2;
  localparam int unsigned CNTW = $clog2(CW + 1);
  localparam int unsigned RW   = 4 * WS + 4 * WD;

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_LOADING = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]   shadow_q, shadow_d;
  logic [CW-1:0]   active_q, active_d;
  logic            err_d;

  // Config next-state: commit wins over a same-cycle shift.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    err_d    = 1'b0;
    if (cfg_commit) begin
      if (state_q == ST_FULL) begin
        active_d = shadow_q;
        cnt_d    = '0;
        state_d  = ST_EMPTY;
      end else begin
        err_d = 1'b1;
      end
    end else if (cfg_en) begin
      shadow_d = {cfg_in, shadow_q[CW-1:1]};
      if (cnt_q != CNTW'(CW)) cnt_d = cnt_q + CNTW'(1);
      state_d = (cnt_d == CNTW'(CW)) ? ST_FULL : ST_LOADING;
    end
  end

  // Config state register; active resets to all-ones so every routed output is off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '1;
      cfg_err  <= 1'b0;
      cfg_full <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      cfg_err  <= err_d;
      cfg_full <= (state_d == ST_FULL);
    end
  end

  assign cfg_out = shadow_q[0];

  // Side-packed track vectors, side index per clb_pkg order.
  logic [4*WS-1:0] s_in_f, s_rt_f;
  logic [4*WD-1:0] d_in_f, d_rt_f;
  logic [RW-1:0]   route_c, route_o;

  assign s_in_f = {west_single_in, south_single_in, east_single_in, north_single_in};
  assign d_in_f = {west_double_in, south_double_in, east_double_in, north_double_in};

  for (genvar o = 0; o < 4; o++) begin : g_side
    localparam int unsigned S0 = src_side(o, 0);
    localparam int unsigned S1 = src_side(o, 1);
    localparam int unsigned S2 = src_side(o, 2);

    for (genvar t = 0; t < WS; t++) begin : g_single
      clb_sb_mux4 u_mux (
        .d0  (s_in_f[S0*WS + t]),
        .d1  (s_in_f[S1*WS + t]),
        .d2  (s_in_f[S2*WS + t]),
        .sel (active_q[8*t + 2*o +: 2]),
        .y_c (s_rt_f[o*WS + t])
      );
    end

    for (genvar i = 0; i < HD; i++) begin : g_double
      localparam int unsigned OP = o * WD + dbl_pos(o, i, HD);
      localparam int unsigned I0 = S0 * WD + dbl_pos(S0, i, HD);
      localparam int unsigned I1 = S1 * WD + dbl_pos(S1, i, HD);
      localparam int unsigned I2 = S2 * WD + dbl_pos(S2, i, HD);
      clb_sb_mux4 u_mux (
        .d0  (d_in_f[I0]),
        .d1  (d_in_f[I1]),
        .d2  (d_in_f[I2]),
        .sel (active_q[8*WS + 8*i + 2*o +: 2]),
        .y_c (d_rt_f[OP])
      );
    end
  end

  // Fixed double-length pass-through, staggered by half a track group.
  for (genvar i = 0; i < HD; i++) begin : g_pass
    assign d_rt_f[SIDE_N*WD + HD + i] = d_in_f[SIDE_S*WD + i];
    assign d_rt_f[SIDE_S*WD + i]      = d_in_f[SIDE_N*WD + HD + i];
    assign d_rt_f[SIDE_E*WD + i]      = d_in_f[SIDE_W*WD + HD + i];
    assign d_rt_f[SIDE_W*WD + HD + i] = d_in_f[SIDE_E*WD + i];
  end

  assign route_c = {d_rt_f, s_rt_f};

  // Optional output register stage.
  if (REG_OUT != 0) begin : g_reg
    logic [RW-1:0] out_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) out_q <= '0;
      else     out_q <= route_c;
    end
    assign route_o = out_q;
  end else begin : g_comb
    assign route_o = route_c;
  end

  assign north_single_out = route_o[SIDE_N*WS +: WS];
  assign east_single_out  = route_o[SIDE_E*WS +: WS];
  assign south_single_out = route_o[SIDE_S*WS +: WS];
  assign west_single_out  = route_o[SIDE_W*WS +: WS];
  assign north_double_out = route_o[4*WS + SIDE_N*WD +: WD];
  assign east_double_out  = route_o[4*WS + SIDE_E*WD +: WD];
  assign south_double_out = route_o[4*WS + SIDE_S*WD +: WD];
  assign west_double_out  = route_o[4*WS + SIDE_W*WD +: WD];

endmodule
